// File: rtl/ata_pio_target_if.sv
// ata_pio_target_if: ATA PIO bus plus backend service port of the emulated
// device.
//   ATA side     : IDECS, DA, IOR, IOW, DIN (from host); DOUT, DOE, IDEWAIT (to host)
//   Backend side : BK_REQ, BK_CMD, BK_LBA, BK_RDATA (to backend);
//                  BK_DONE, BK_ERR, BK_ADDR, BK_WE, BK_WDATA (from backend)
// The slave modport is the device view; master is the host + backend view.
interface ata_pio_target_if;
    logic [1:0]  IDECS;
    logic [2:0]  DA;
    logic        IOR;
    logic        IOW;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        DOE;
    logic        IDEWAIT;
    logic        BK_REQ;
    logic [7:0]  BK_CMD;
    logic [23:0] BK_LBA;
    logic        BK_DONE;
    logic        BK_ERR;
    logic [7:0]  BK_ADDR;
    logic        BK_WE;
    logic [15:0] BK_WDATA;
    logic [15:0] BK_RDATA;

    modport slave (
        input  IDECS, DA, IOR, IOW, DIN, BK_DONE, BK_ERR, BK_ADDR, BK_WE, BK_WDATA,
        output DOUT, DOE, IDEWAIT, BK_REQ, BK_CMD, BK_LBA, BK_RDATA
    );

    modport master (
        output IDECS, DA, IOR, IOW, DIN, BK_DONE, BK_ERR, BK_ADDR, BK_WE, BK_WDATA,
        input  DOUT, DOE, IDEWAIT, BK_REQ, BK_CMD, BK_LBA, BK_RDATA
    );
endinterface

// File: rtl/ata_pio_target.sv
// ata_pio_target: device-side ATA PIO responder. Synchronises the host
// strobes, decodes the task file, owns a 256x16 sector buffer and runs the
// BSY/DRQ command state machine; a backend port fills/drains the buffer.
// Ports:
//   CLK   - system clock
//   RESET - asynchronous active-low reset
//   bus   - ata_pio_target_if.slave (ATA bus + backend port)
module ata_pio_target #(
    parameter int         WAIT_CYCLES = 2,
    parameter logic [7:0] STATUS_IDLE = 8'h50
) (
    input logic             CLK,
    input logic             RESET,
    ata_pio_target_if.slave bus
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD_BUSY, S_XFER_OUT, S_XFER_IN, S_FLUSH, S_SRST
    } state_t;

    state_t      state_q, state_d;
    logic        ior_s1_q, ior_s2_q, ior_s3_q, iow_s1_q, iow_s2_q, iow_s3_q;
    logic [1:0]  cs_q, cs_d;
    logic [2:0]  da_q, da_d;
    logic [15:0] din_q, din_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  seccnt_q, seccnt_d, lba0_q, lba0_d, lba1_q, lba1_d, lba2_q, lba2_d;
    logic [7:0]  device_q, device_d, cmd_q, cmd_d, err_reg_q, err_reg_d;
    logic        err_bit_q, err_bit_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic        idewait_q, idewait_d, doe_q, doe_d, bk_req_q, bk_req_d;
    logic [15:0] dout_q, dout_d, bk_rdata_q, bk_rdata_d;

    logic [15:0] mem [256];
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;

    logic sel_cs0, sel_cs1, is_data, bsy, drq, xfer;
    logic ior_fall, ior_rise, iow_fall, iow_rise;
    logic [7:0]  status_byte;
    logic [15:0] rd_data;

    assign sel_cs0  = (cs_q == 2'b10);
    assign sel_cs1  = (cs_q == 2'b01);
    assign is_data  = sel_cs0 && (da_q == 3'd0);
    assign ior_fall = !ior_s2_q && ior_s3_q;
    assign ior_rise = ior_s2_q && !ior_s3_q;
    assign iow_fall = !iow_s2_q && iow_s3_q;
    assign iow_rise = iow_s2_q && !iow_s3_q;
    assign bsy  = (state_q == S_CMD_BUSY) || (state_q == S_FLUSH) || (state_q == S_SRST);
    assign xfer = (state_q == S_XFER_OUT) || (state_q == S_XFER_IN);
    assign drq  = xfer;
    // Fixed status bits (DRDY/DSC) come from STATUS_IDLE; BSY/DRQ/ERR are live.
    assign status_byte = (STATUS_IDLE & 8'h76) | {bsy, 3'b000, drq, 2'b00, err_bit_q};

    assign bus.DOUT     = dout_q;
    assign bus.DOE      = doe_q;
    assign bus.IDEWAIT  = idewait_q;
    assign bus.BK_REQ   = bk_req_q;
    assign bus.BK_CMD   = cmd_q;
    assign bus.BK_LBA   = {lba2_q, lba1_q, lba0_q};
    assign bus.BK_RDATA = bk_rdata_q;

    // Read mux on the address captured during the strobe.
    always_comb begin
        rd_data = 16'h0000;
        if (sel_cs0) begin
            case (da_q)
                3'd0: rd_data = xfer ? mem[ptr_q] : 16'h0000;
                3'd1: rd_data = {8'h00, err_reg_q};
                3'd2: rd_data = {8'h00, seccnt_q};
                3'd3: rd_data = {8'h00, lba0_q};
                3'd4: rd_data = {8'h00, lba1_q};
                3'd5: rd_data = {8'h00, lba2_q};
                3'd6: rd_data = {8'h00, device_q};
                default: rd_data = {8'h00, status_byte};
            endcase
        end else if (sel_cs1) begin
            rd_data = (da_q == 3'd6) ? {8'h00, status_byte} : 16'hFFFF;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path infers a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        seccnt_d  = seccnt_q;
        lba0_d    = lba0_q;
        lba1_d    = lba1_q;
        lba2_d    = lba2_q;
        device_d  = device_q;
        cmd_d     = cmd_q;
        err_reg_d = err_reg_q;
        err_bit_d = err_bit_q;
        mem_we    = 1'b0;
        mem_waddr = bus.BK_ADDR;
        mem_wdata = bus.BK_WDATA;

        // Address/data are captured while the first sync stage sees a strobe,
        // so they are frozen by the time the synced rising edge is seen.
        cs_d  = (!ior_s1_q || !iow_s1_q) ? bus.IDECS : cs_q;
        da_d  = (!ior_s1_q || !iow_s1_q) ? bus.DA    : da_q;
        din_d = (!iow_s1_q)              ? bus.DIN   : din_q;

        if (bk_req_q && bus.BK_WE) mem_we = 1'b1;

        if (bus.BK_DONE) begin
            if (state_q == S_CMD_BUSY) begin
                if (cmd_q == 8'h20 || cmd_q == 8'hEC) begin
                    if (bus.BK_ERR) begin
                        state_d   = S_IDLE;
                        err_bit_d = 1'b1;
                        err_reg_d = 8'h04;
                    end else begin
                        state_d = S_XFER_OUT;
                        ptr_d   = 8'd0;
                    end
                end else begin
                    state_d   = S_IDLE;
                    err_bit_d = bus.BK_ERR;
                    if (bus.BK_ERR) err_reg_d = 8'h04;
                end
            end else if (state_q == S_FLUSH) begin
                state_d   = S_IDLE;
                err_bit_d = bus.BK_ERR;
                if (bus.BK_ERR) err_reg_d = 8'h04;
            end
        end

        if (ior_rise && is_data && state_q == S_XFER_OUT) begin
            ptr_d = ptr_q + 8'd1;
            if (ptr_q == 8'd255) state_d = S_IDLE;
        end

        if (iow_rise && sel_cs0) begin
            case (da_q)
                3'd0: if (state_q == S_XFER_IN) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = din_q;
                    ptr_d     = ptr_q + 8'd1;
                    if (ptr_q == 8'd255) state_d = S_FLUSH;
                end
                // Features (DA=1) has no readback and no consumer: discarded.
                3'd2: if (!bsy) seccnt_d = din_q[7:0];
                3'd3: if (!bsy) lba0_d   = din_q[7:0];
                3'd4: if (!bsy) lba1_d   = din_q[7:0];
                3'd5: if (!bsy) lba2_d   = din_q[7:0];
                3'd6: if (!bsy) device_d = din_q[7:0];
                3'd7: if (state_q == S_IDLE) begin
                    cmd_d     = din_q[7:0];
                    err_bit_d = 1'b0;
                    err_reg_d = 8'h00;
                    ptr_d     = 8'd0;
                    state_d   = (din_q[7:0] == 8'h30) ? S_XFER_IN : S_CMD_BUSY;
                end
                default: ;
            endcase
        end

        // Device control overrides everything else, including a same-cycle BK_DONE.
        if (iow_rise && sel_cs1 && da_q == 3'd6) begin
            if (din_q[2]) begin
                state_d   = S_SRST;
                ptr_d     = 8'd0;
                err_bit_d = 1'b0;
            end else if (state_q == S_SRST) begin
                state_d   = S_IDLE;
                err_reg_d = 8'h01;
            end
        end

        if (is_data && (ior_fall || iow_fall)) wait_cnt_d = WCW'(WAIT_CYCLES);
        else if (wait_cnt_q != '0)             wait_cnt_d = wait_cnt_q - 1'b1;
        else                                   wait_cnt_d = wait_cnt_q;
        idewait_d = (wait_cnt_d == '0);

        doe_d      = !ior_s2_q && (sel_cs0 || sel_cs1);
        dout_d     = doe_d ? rd_data : 16'h0000;
        bk_req_d   = (state_d == S_CMD_BUSY) || (state_d == S_FLUSH);
        bk_rdata_d = bk_req_q ? mem[bus.BK_ADDR] : bk_rdata_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            ior_s1_q   <= 1'b1;
            ior_s2_q   <= 1'b1;
            ior_s3_q   <= 1'b1;
            iow_s1_q   <= 1'b1;
            iow_s2_q   <= 1'b1;
            iow_s3_q   <= 1'b1;
            cs_q       <= 2'b11;
            da_q       <= 3'd0;
            din_q      <= 16'h0000;
            ptr_q      <= 8'd0;
            seccnt_q   <= 8'h00;
            lba0_q     <= 8'h00;
            lba1_q     <= 8'h00;
            lba2_q     <= 8'h00;
            device_q   <= 8'h00;
            cmd_q      <= 8'h00;
            err_reg_q  <= 8'h00;
            err_bit_q  <= 1'b0;
            wait_cnt_q <= '0;
            idewait_q  <= 1'b1;
            doe_q      <= 1'b0;
            dout_q     <= 16'h0000;
            bk_req_q   <= 1'b0;
            bk_rdata_q <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            ior_s1_q   <= bus.IOR;
            ior_s2_q   <= ior_s1_q;
            ior_s3_q   <= ior_s2_q;
            iow_s1_q   <= bus.IOW;
            iow_s2_q   <= iow_s1_q;
            iow_s3_q   <= iow_s2_q;
            cs_q       <= cs_d;
            da_q       <= da_d;
            din_q      <= din_d;
            ptr_q      <= ptr_d;
            seccnt_q   <= seccnt_d;
            lba0_q     <= lba0_d;
            lba1_q     <= lba1_d;
            lba2_q     <= lba2_d;
            device_q   <= device_d;
            cmd_q      <= cmd_d;
            err_reg_q  <= err_reg_d;
            err_bit_q  <= err_bit_d;
            wait_cnt_q <= wait_cnt_d;
            idewait_q  <= idewait_d;
            doe_q      <= doe_d;
            dout_q     <= dout_d;
            bk_req_q   <= bk_req_d;
            bk_rdata_q <= bk_rdata_d;
        end
    end

    // NOTE: the sector buffer is deliberately not reset; its contents are
    // undefined after reset and a reset would prevent RAM inference.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_ata_pio_target.sv
module tb_ata_pio_target;
    localparam int WAIT_CYCLES = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    ata_pio_target_if bus ();

    ata_pio_target #(.WAIT_CYCLES(WAIT_CYCLES), .STATUS_IDLE(8'h50)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int wait_low = 0;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each DOE assertion is one host read; compare against the queue.
    logic doe_prev = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (bus.DOE === 1'b1 && !doe_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %0h expected none", bus.DOUT);
            end else begin
                e = sb_q.pop_front();
                check(e.name, {16'h0, bus.DOUT}, {16'h0, e.exp});
            end
        end
        doe_prev = (bus.DOE === 1'b1);
    end

    always @(negedge CLK) if (bus.IDEWAIT === 1'b0) wait_low++;

    task automatic host_read(input logic [1:0] cs, input logic [2:0] da,
                             input logic [15:0] exp, input string name);
        sb_q.push_back('{name, exp});
        @(negedge CLK);
        bus.IDECS = cs;
        bus.DA    = da;
        repeat (2) @(negedge CLK);
        bus.IOR = 1'b0;
        repeat (8) @(negedge CLK);
        bus.IOR = 1'b1;
        repeat (4) @(negedge CLK);
        bus.IDECS = 2'b11;
    endtask

    task automatic host_write(input logic [1:0] cs, input logic [2:0] da, input logic [15:0] d);
        @(negedge CLK);
        bus.IDECS = cs;
        bus.DA    = da;
        bus.DIN   = d;
        repeat (2) @(negedge CLK);
        bus.IOW = 1'b0;
        repeat (8) @(negedge CLK);
        bus.IOW = 1'b1;
        repeat (4) @(negedge CLK);
        bus.IDECS = 2'b11;
    endtask

    task automatic bk_fill(input logic [15:0] base);
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            bus.BK_WE    = 1'b1;
            bus.BK_ADDR  = 8'(i);
            bus.BK_WDATA = base + 16'(i);
        end
        @(negedge CLK);
        bus.BK_WE = 1'b0;
    endtask

    task automatic bk_done(input logic err);
        @(negedge CLK);
        bus.BK_DONE = 1'b1;
        bus.BK_ERR  = err;
        @(negedge CLK);
        bus.BK_DONE = 1'b0;
        bus.BK_ERR  = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IDECS = 2'b11; bus.DA = 3'd0; bus.IOR = 1'b1; bus.IOW = 1'b1; bus.DIN = 16'h0;
        bus.BK_DONE = 1'b0; bus.BK_ERR = 1'b0; bus.BK_ADDR = 8'h0; bus.BK_WE = 1'b0;
        bus.BK_WDATA = 16'h0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_doe", {31'h0, bus.DOE}, 32'h0);
        check("rst_idewait", {31'h0, bus.IDEWAIT}, 32'h1);
        check("rst_bk_req", {31'h0, bus.BK_REQ}, 32'h0);
        check("rst_dout", {16'h0, bus.DOUT}, 32'h0);

        // Status read after reset; no data-register access so IDEWAIT stays 1.
        wait_low = 0;
        host_read(2'b10, 3'd7, 16'h0050, "status_reset");
        check("doe_after_ior", {31'h0, bus.DOE}, 32'h0);
        check("idewait_status_rd", wait_low, 0);
        host_read(2'b01, 3'd5, 16'hFFFF, "cs1_unmapped");

        // Read sector.
        host_write(2'b10, 3'd3, 16'h0012);
        host_write(2'b10, 3'd4, 16'h0034);
        host_write(2'b10, 3'd5, 16'h0056);
        host_write(2'b10, 3'd7, 16'h0020);
        check("rd_bk_req", {31'h0, bus.BK_REQ}, 32'h1);
        check("rd_bk_lba", {8'h0, bus.BK_LBA}, 32'h563412);
        check("rd_bk_cmd", {24'h0, bus.BK_CMD}, 32'h20);
        host_read(2'b10, 3'd7, 16'h00D0, "status_busy");
        bk_fill(16'h0000);
        bk_done(1'b0);
        host_read(2'b10, 3'd7, 16'h0058, "status_drq");
        for (int i = 0; i < 256; i++) host_read(2'b10, 3'd0, 16'(i), "rd_data");
        host_read(2'b10, 3'd7, 16'h0050, "status_after_rd");

        // Write sector.
        host_write(2'b10, 3'd7, 16'h0030);
        host_read(2'b10, 3'd7, 16'h0058, "status_wr_drq");
        for (int i = 0; i < 256; i++) host_write(2'b10, 3'd0, 16'hA500 + 16'(i));
        host_read(2'b10, 3'd7, 16'h00D0, "status_flush");
        check("flush_bk_req", {31'h0, bus.BK_REQ}, 32'h1);
        @(negedge CLK);
        bus.BK_ADDR = 8'd7;
        @(negedge CLK);
        check("bk_rdata_7", {16'h0, bus.BK_RDATA}, 32'hA507);
        bk_done(1'b0);
        host_read(2'b10, 3'd7, 16'h0050, "status_after_wr");

        // Aborted command, then a new command clears ERR.
        host_write(2'b10, 3'd7, 16'h0020);
        bk_done(1'b1);
        host_read(2'b10, 3'd7, 16'h0051, "status_err");
        host_read(2'b10, 3'd1, 16'h0004, "error_reg_abort");
        host_write(2'b10, 3'd7, 16'h00E5);
        host_read(2'b10, 3'd7, 16'h00D0, "status_other_busy");
        host_read(2'b10, 3'd1, 16'h0000, "error_reg_cleared");
        bk_done(1'b0);
        host_read(2'b10, 3'd7, 16'h0050, "status_other_done");

        // Soft reset in the middle of a read transfer.
        host_write(2'b10, 3'd7, 16'h0020);
        bk_fill(16'h0100);
        bk_done(1'b0);
        for (int i = 0; i < 10; i++) host_read(2'b10, 3'd0, 16'h0100 + 16'(i), "rd_partial");
        host_write(2'b01, 3'd6, 16'h0004);
        host_read(2'b01, 3'd6, 16'h00D0, "alt_status_srst");
        check("srst_bk_req", {31'h0, bus.BK_REQ}, 32'h0);
        host_write(2'b01, 3'd6, 16'h0000);
        host_read(2'b10, 3'd7, 16'h0050, "status_after_srst");
        host_read(2'b10, 3'd1, 16'h0001, "error_reg_srst");
        host_write(2'b10, 3'd7, 16'h0020);
        bk_done(1'b0);
        for (int i = 0; i < 256; i++) host_read(2'b10, 3'd0, 16'h0100 + 16'(i), "rd_restart");
        host_read(2'b10, 3'd7, 16'h0050, "status_restart_done");

        // Deselected write is ignored; data-register read outside XFER.
        host_write(2'b00, 3'd7, 16'h0020);
        check("nosel_bk_req", {31'h0, bus.BK_REQ}, 32'h0);
        host_read(2'b10, 3'd7, 16'h0050, "status_nosel");
        wait_low = 0;
        host_read(2'b10, 3'd0, 16'h0000, "data_idle");
        check("idewait_cycles", wait_low, WAIT_CYCLES);

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ata_pio_target.md
Name: ata_pio_target

Overview:
- Device-side responder for the ATA PIO bus: the other end of the host PIO strobe generator.
- Decodes IDECS/DA/IOR/IOW, implements the task-file registers, a 256x16 sector buffer and the BSY/DRQ command state machine, and drives read data plus IDEWAIT.
- Used as a CompactFlash/IDE emulation target and as the reference device in accelerator benches.
- A simple backend port fills and drains the sector buffer and completes commands.

Parameters:
- WAIT_CYCLES, 2, CLK cycles IDEWAIT is held low after a data-register strobe edge is detected (0 disables).
- STATUS_IDLE, 8'h50, status value when idle (DRDY|DSC).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous active-low reset.
- IDECS  in  2  active-low chip selects; [0]=CS0 (command block), [1]=CS1 (control block).
- DA  in  3  register address.
- IOR  in  1  active-low read strobe, asynchronous to CLK.
- IOW  in  1  active-low write strobe, asynchronous to CLK.
- DIN  in  16  host write data.
- DOUT  out  16  read data.
- DOE  out  1  high = drive DOUT onto the bus.
- IDEWAIT  out  1  active-low IORDY; low = host must extend the strobe.
- BK_REQ  out  1  level; backend service requested.
- BK_CMD  out  8  latched command byte.
- BK_LBA  out  24  {lba2, lba1, lba0}.
- BK_DONE  in  1  one-cycle pulse; backend finished.
- BK_ERR  in  1  sampled with BK_DONE; abort the command.
- BK_ADDR  in  8  buffer word address.
- BK_WE  in  1  buffer write enable.
- BK_WDATA  in  16  buffer write data.
- BK_RDATA  out  16  buffer read data, registered, 1-cycle latency.

Behaviour:
- IOR and IOW pass through 2-flop synchronisers; fall and rise edges are detected on the synced signals. IDECS, DA and DIN are sampled with the synced strobe.
- Select: CS0 = IDECS==2'b10; CS1 = IDECS==2'b01. Any other IDECS value selects nothing: no DOE, writes ignored.
- CS0 register map by DA:
  - 0: data
  - 1: error (read) / features (write)
  - 2: sector count
  - 3: lba0
  - 4: lba1
  - 5: lba2
  - 6: device
  - 7: status (read) / command (write)
- CS1 register map: DA=6 is alt-status (read) / device control (write). Other CS1 addresses read 16'hFFFF and ignore writes.
- Reads:
  - DOE=1 and DOUT valid while synced IOR is low and a register is selected. DOUT is registered.
  - 8-bit registers return {8'h00, reg}.
  - Data-register read returns buf[ptr]. ptr increments on the synced IOR rising edge, only in XFER_OUT.
- Writes: committed on the synced IOW rising edge using the DA/DIN sampled at that edge. Data-register write stores buf[ptr] and increments ptr, only in XFER_IN.
- IDEWAIT: driven low for WAIT_CYCLES cycles starting at a detected falling edge of IOR or IOW on the data register. It is 1 at all other times.
- Status byte: {BSY, 1, 0, 1, DRQ, 0, 0, ERR}. Reset value = STATUS_IDLE.
- Error register: 8'h04 after an aborted command. It is cleared when a new command is accepted.
- Task-file writes (DA 1–6) and command writes are ignored while BSY=1. Device control is always writable.
- FSM states:
  - IDLE: BSY=0, DRQ=0.
  - CMD_BUSY: BSY=1, BK_REQ=1.
  - XFER_OUT: DRQ=1.
  - XFER_IN: DRQ=1.
  - FLUSH: BSY=1, BK_REQ=1.
  - SRST: BSY=1.
- Transitions from IDLE on a command write (BK_CMD latched, ERR cleared, ptr=0):
  - 8'h20 (read) or 8'hEC (identify) -> CMD_BUSY. On BK_DONE: -> XFER_OUT, or -> IDLE with ERR=1 if BK_ERR.
  - 8'h30 (write) -> XFER_IN.
  - Any other command -> CMD_BUSY. On BK_DONE: -> IDLE; ERR=BK_ERR.
- Transfer completion:
  - XFER_OUT: after the 256th data read (ptr wraps 255->0) -> IDLE.
  - XFER_IN: after the 256th data write -> FLUSH. On BK_DONE -> IDLE; ERR=BK_ERR.
- Single sector per command; the sector count register is stored only.
- Device control bit2 (SRST) written 1: any state -> SRST, ptr=0, BK_REQ=0. Writing SRST=0 -> IDLE with status = STATUS_IDLE and error register = 8'h01.
- BK_DONE outside CMD_BUSY/FLUSH is ignored.
- Sector buffer arbitration: the backend port is honoured only when BK_REQ=1. The host port is honoured only in XFER states. There is no simultaneous access.
- Data-register access outside XFER states: reads return 16'h0000; writes are ignored; ptr does not move.
- RESET low (async): FSM -> IDLE, ptr=0, all registers 0 except status = STATUS_IDLE, DOE=0, IDEWAIT=1, BK_REQ=0, DOUT=0. Buffer contents are undefined.

Test Plan:
- Reset, then read CS0 DA=7 -> DOUT=16'h0050, DOE high only during IOR low; IDEWAIT stays 1.
- Write lba0..lba2 = 12/34/56 and command 8'h20 -> status 8'hD0, BK_REQ=1, BK_LBA=24'h563412, BK_CMD=8'h20. Backend fills buf[i]=i, BK_DONE -> status 8'h58. Then 256 data reads -> return 0..255; status returns to 8'h50.
- Command 8'h30, then 256 writes of 16'hA500+i -> status 8'hD0 and BK_REQ=1. Backend reads buf[7] -> 16'hA507. BK_DONE -> 8'h50.
- Command 8'h20 answered with BK_DONE plus BK_ERR -> status 8'h51, error register 8'h04. The next command clears ERR.
- Mid-XFER_OUT after 10 reads, write device control 8'h04 then 8'h00 -> status 8'hD0, then 8'h50. The next read command restarts at buf[0].
- IDECS=2'b00 with an IOW to DA=7 -> no state change. Data-register IOR -> IDEWAIT low for exactly WAIT_CYCLES CLK cycles.
